// File: rtl/light_state_detect_pkg.sv
// light_state_detect_pkg: overlay character indices, FSM states and default video geometry.
package light_state_detect_pkg;
   localparam logic [7:0] CHAR_DIGIT_0 = 8'd0;
   localparam logic [7:0] CHAR_DIGIT_1 = 8'd1;
   localparam logic [7:0] CHAR_DIGIT_2 = 8'd2;
   localparam logic [7:0] CHAR_DIGIT_3 = 8'd3;
   localparam logic [7:0] CHAR_DIGIT_4 = 8'd4;
   localparam logic [7:0] CHAR_DIGIT_5 = 8'd5;
   localparam logic [7:0] CHAR_DIGIT_6 = 8'd6;
   localparam logic [7:0] CHAR_DIGIT_7 = 8'd7;
   localparam logic [7:0] CHAR_DIGIT_8 = 8'd8;
   localparam logic [7:0] CHAR_DIGIT_9 = 8'd9;
   localparam logic [7:0] CHAR_RED     = 8'd10;
   localparam logic [7:0] CHAR_GREEN   = 8'd11;
   localparam logic [7:0] CHAR_NONE    = 8'd15;
   localparam int HREF_DEF  = 640;
   localparam int VSYNC_DEF = 480;
   typedef enum logic [1:0] {IDLE, ARM, ACCUM, DECIDE} state_t;
endpackage

// File: rtl/light_state_detect_pixel_color_class.sv
// pixel_color_class: flags one RGB888 pixel as red-lit and/or green-lit against programmable thresholds.
module pixel_color_class (
   input  logic [23:0] data,
   input  logic [7:0]  red_r_min,
   input  logic [7:0]  red_gb_max,
   input  logic [7:0]  grn_g_min,
   input  logic [7:0]  grn_r_max,
   output logic [1:0]  cls
);
   logic [7:0] r, g, b;
   logic is_red;
   assign r = data[23:16];
   assign g = data[15:8];
   assign b = data[7:0];
   assign is_red = r >= red_r_min && g <= red_gb_max && b <= red_gb_max;
   // red wins so the two flags stay exclusive even with overlapping thresholds
   assign cls = {is_red, !is_red && g >= grn_g_min && r <= grn_r_max};
endmodule

// File: rtl/light_state_detect.sv
// light_state_detect: 1-cycle RGB passthrough that counts red/green pixels in an ROI per frame
// and drives a debounced light-state character index for the overlay stage.
module light_state_detect
   import light_state_detect_pkg::*;
#(
   parameter int HREF          = HREF_DEF,
   parameter int VSYNC         = VSYNC_DEF,
   parameter int ROI_X0        = 0,
   parameter int ROI_X1        = 639,
   parameter int ROI_Y0        = 0,
   parameter int ROI_Y1        = 239,
   parameter int RED_R_MIN     = 180,
   parameter int RED_GB_MAX    = 90,
   parameter int GRN_G_MIN     = 160,
   parameter int GRN_R_MAX     = 100,
   parameter int PIX_TH        = 200,
   parameter int STABLE_FRAMES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsycn_i,
   input  logic        vsync_i,
   input  logic        de_i,
   input  logic [23:0] data_i,
   output logic        hsycn_o,
   output logic        vsync_o,
   output logic        de_o,
   output logic [23:0] data_o,
   output logic [7:0]  char_0,
   output logic        char_valid
);
   state_t      state;
   logic [10:0] x_cnt;
   logic [9:0]  y_cnt;
   logic [18:0] red_cnt, green_cnt;
   logic [7:0]  candidate, stab_cnt, stab_nxt, cls_char;
   logic [1:0]  cls;
   logic        in_roi;
   pixel_color_class u_class (
      .data      (data_i),
      .red_r_min (8'(RED_R_MIN)),
      .red_gb_max(8'(RED_GB_MAX)),
      .grn_g_min (8'(GRN_G_MIN)),
      .grn_r_max (8'(GRN_R_MAX)),
      .cls       (cls)
   );
   always_comb begin
      in_roi = de_i && int'(x_cnt) >= ROI_X0 && int'(x_cnt) <= ROI_X1
                    && int'(y_cnt) >= ROI_Y0 && int'(y_cnt) <= ROI_Y1;
      cls_char = (red_cnt >= 19'(PIX_TH) && red_cnt >= green_cnt) ? CHAR_RED
               : (green_cnt >= 19'(PIX_TH)) ? CHAR_GREEN : CHAR_NONE;
      stab_nxt = (cls_char != candidate) ? 8'd1
               : (stab_cnt == 8'(STABLE_FRAMES)) ? stab_cnt : stab_cnt + 8'd1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         hsycn_o    <= 1'b0;
         vsync_o    <= 1'b0;
         de_o       <= 1'b0;
         data_o     <= '0;
         state      <= IDLE;
         x_cnt      <= '0;
         y_cnt      <= '0;
         red_cnt    <= '0;
         green_cnt  <= '0;
         candidate  <= CHAR_NONE;
         stab_cnt   <= '0;
         char_0     <= CHAR_NONE;
         char_valid <= 1'b0;
      end else begin
         hsycn_o    <= hsycn_i;
         vsync_o    <= vsync_i;
         de_o       <= de_i;
         data_o     <= data_i;
         char_valid <= 1'b0;
         if (!vsync_i) begin
            x_cnt <= '0;
            y_cnt <= '0;
         end else if (de_i) begin
            x_cnt <= (int'(x_cnt) == HREF - 1) ? '0 : x_cnt + 11'd1;
            if (int'(x_cnt) == HREF - 1 && int'(y_cnt) != VSYNC - 1) y_cnt <= y_cnt + 10'd1;
         end
         case (state)
            IDLE: if (!vsync_i) state <= ARM;
            ARM: begin
               red_cnt   <= '0;
               green_cnt <= '0;
               if (vsync_i) state <= ACCUM;
            end
            ACCUM: begin
               if (!vsync_i) state <= DECIDE;
               else if (in_roi) begin
                  if (cls[1] && !(&red_cnt)) red_cnt <= red_cnt + 19'd1;
                  if (cls[0] && !(&green_cnt)) green_cnt <= green_cnt + 19'd1;
               end
            end
            DECIDE: begin
               candidate <= cls_char;
               stab_cnt  <= stab_nxt;
               state     <= ARM;
               if (stab_nxt == 8'(STABLE_FRAMES) && cls_char != char_0) begin
                  char_0     <= cls_char;
                  char_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_light_state_detect.sv
// tb_light_state_detect: randomized frames against a frame-history reference model on three
// configurations (full ROI / ROI_X0=1 / single-frame debounce).
module tb_light_state_detect;
   localparam int H = 16, V = 8, N = H * V, TH = 20;
   logic        clk = 1'b0, rst = 1'b0, hs = 1'b0, vs = 1'b0, de = 1'b0;
   logic [23:0] dat = '0;
   logic        hs_o [3], vs_o [3], de_o [3], cv [3];
   logic [23:0] d_o [3];
   logic [7:0]  ch [3];
   int checks = 0, failures = 0;
   logic [23:0] pix [N];
   int x0 [3] = '{0, 1, 0};
   int sf [3] = '{3, 3, 1};
   int hist [3][$];
   int disp [3], prev [3], pulses [3];
   bit chg [3];
   logic [7:0] c1 [3], c2 [3], rc [3];
   logic v1 [3], v2 [3], v3 [3], rv [3];

   always #5 clk = ~clk;

   light_state_detect #(.HREF(H), .VSYNC(V), .ROI_X0(0), .ROI_X1(15), .ROI_Y0(0), .ROI_Y1(7),
      .PIX_TH(TH), .STABLE_FRAMES(3)) dut_a (.clk(clk), .rst(rst), .hsycn_i(hs), .vsync_i(vs),
      .de_i(de), .data_i(dat), .hsycn_o(hs_o[0]), .vsync_o(vs_o[0]), .de_o(de_o[0]),
      .data_o(d_o[0]), .char_0(ch[0]), .char_valid(cv[0]));
   light_state_detect #(.HREF(H), .VSYNC(V), .ROI_X0(1), .ROI_X1(15), .ROI_Y0(0), .ROI_Y1(7),
      .PIX_TH(TH), .STABLE_FRAMES(3)) dut_b (.clk(clk), .rst(rst), .hsycn_i(hs), .vsync_i(vs),
      .de_i(de), .data_i(dat), .hsycn_o(hs_o[1]), .vsync_o(vs_o[1]), .de_o(de_o[1]),
      .data_o(d_o[1]), .char_0(ch[1]), .char_valid(cv[1]));
   light_state_detect #(.HREF(H), .VSYNC(V), .ROI_X0(0), .ROI_X1(15), .ROI_Y0(0), .ROI_Y1(7),
      .PIX_TH(TH), .STABLE_FRAMES(1)) dut_c (.clk(clk), .rst(rst), .hsycn_i(hs), .vsync_i(vs),
      .de_i(de), .data_i(dat), .hsycn_o(hs_o[2]), .vsync_o(vs_o[2]), .de_o(de_o[2]),
      .data_o(d_o[2]), .char_0(ch[2]), .char_valid(cv[2]));

   task automatic tick();
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) pulses[k] += (cv[k] === 1'b1) ? 1 : 0;
   endtask

   function automatic logic [23:0] red_px();
      return {8'($urandom_range(255, 180)), 8'($urandom_range(90, 0)), 8'($urandom_range(90, 0))};
   endfunction

   function automatic logic [23:0] grn_px();
      return {8'($urandom_range(100, 0)), 8'($urandom_range(255, 160)), 8'($urandom_range(255, 0))};
   endfunction

   // background pixels have 100 < R < 180, so they are neither red nor green
   task automatic fill(input int nr, input int ng);
      int pos [N];
      int j, t;
      for (int i = 0; i < N; i++) begin
         pos[i] = i;
         pix[i] = {8'($urandom_range(179, 101)), 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0))};
      end
      for (int i = N - 1; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = pos[i]; pos[i] = pos[j]; pos[j] = t;
      end
      for (int i = 0; i < nr + ng; i++) pix[pos[i]] = (i < nr) ? red_px() : grn_px();
   endtask

   function automatic int classify(input int k, input int npx);
      int r = 0, g = 0;
      logic [7:0] pr, pg, pb;
      for (int i = 0; i < npx; i++) begin
         pr = pix[i][23:16]; pg = pix[i][15:8]; pb = pix[i][7:0];
         if (i % H >= x0[k]) begin
            if (pr >= 180 && pg <= 90 && pb <= 90) r++;
            else if (pg >= 160 && pr <= 100) g++;
         end
      end
      return (r >= TH && r >= g) ? 10 : (g >= TH) ? 11 : 15;
   endfunction

   // displayed state follows the class once the last sf[k] classes since reset agree
   task automatic model_frame(input int npx);
      bit same;
      for (int k = 0; k < 3; k++) begin
         prev[k] = disp[k];
         hist[k].push_back(classify(k, npx));
         same = hist[k].size() >= sf[k];
         for (int j = 1; j <= sf[k] && same; j++)
            if (hist[k][hist[k].size() - j] != hist[k][hist[k].size() - 1]) same = 0;
         chg[k] = same && hist[k][hist[k].size() - 1] != disp[k];
         if (chg[k]) disp[k] = hist[k][hist[k].size() - 1];
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         hist[k].delete();
         disp[k] = 15; prev[k] = 15; chg[k] = 0;
      end
   endtask

   task automatic send_frame(input int npx, input int rst_at);
      vs = 0; de = 0; hs = 0;
      repeat (2) tick();
      vs = 1;
      tick();
      for (int i = 0; i < npx; i++) begin
         de = 1; hs = 1; dat = pix[i]; rst = (i == rst_at);
         tick();
         rst = 0;
         if (i == rst_at) for (int k = 0; k < 3; k++) begin rc[k] = ch[k]; rv[k] = cv[k]; end
         if (i % H == H - 1) begin
            de = 0; hs = 0; dat = 24'h123456;
            repeat (2) tick();
         end
      end
      vs = 0; hs = 0; de = 1; dat = 24'hFF0000;
      tick();
      for (int k = 0; k < 3; k++) begin c1[k] = ch[k]; v1[k] = cv[k]; end
      de = 0;
      tick();
      for (int k = 0; k < 3; k++) begin c2[k] = ch[k]; v2[k] = cv[k]; end
      tick();
      for (int k = 0; k < 3; k++) v3[k] = cv[k];
   endtask

   task automatic test_reset();
      rst = 1; hs = 1; vs = 1; de = 1; dat = 24'hFFFFFF;
      repeat (2) tick();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (hs_o[k] !== 1'b0 || vs_o[k] !== 1'b0 || de_o[k] !== 1'b0 || d_o[k] !== 24'h0
             || ch[k] !== 8'd15 || cv[k] !== 1'b0) begin
            failures++;
            $display("FAIL reset dut%0d: got hs=%b vs=%b de=%b data=%h char=%0d valid=%b, want 0 0 0 000000 15 0",
                     k, hs_o[k], vs_o[k], de_o[k], d_o[k], ch[k], cv[k]);
         end
      end
      rst = 0; hs = 0; vs = 0; de = 0; dat = '0;
      model_reset();
   endtask

   task automatic test_passthrough();
      logic ehs, evs, ede;
      logic [23:0] ed;
      for (int c = 0; c < 40; c++) begin
         ehs = 1'($urandom); evs = 1'($urandom); ede = 1'($urandom); ed = 24'($urandom);
         hs = ehs; vs = evs; de = ede; dat = ed;
         tick();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (hs_o[k] !== ehs || vs_o[k] !== evs || de_o[k] !== ede || d_o[k] !== ed) begin
               failures++;
               $display("FAIL passthrough dut%0d cycle%0d: got %b%b%b %h, want %b%b%b %h",
                        k, c, hs_o[k], vs_o[k], de_o[k], d_o[k], ehs, evs, ede, ed);
            end
         end
      end
      rst = 1; tick(); rst = 0;
      model_reset();
   endtask

   task automatic test_red_debounce();
      int p = pulses[0];
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N; i++) pix[i] = 24'hFF0000;
         send_frame(N, -1);
         model_frame(N);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (c1[k] !== 8'(prev[k]) || v1[k] !== 1'b0 || c2[k] !== 8'(disp[k]) || v2[k] !== chg[k] || v3[k] !== 1'b0) begin
               failures++;
               $display("FAIL red_debounce dut%0d frame%0d: got char %0d->%0d valid %b%b%b, want %0d->%0d valid 0%b0",
                        k, f, c1[k], c2[k], v1[k], v2[k], v3[k], prev[k], disp[k], chg[k]);
            end
         end
      end
      checks++;
      if (ch[0] !== 8'd10 || pulses[0] - p !== 1) begin
         failures++;
         $display("FAIL red_debounce final: got char %0d pulses %0d, want 10 pulses 1", ch[0], pulses[0] - p);
      end
   endtask

   task automatic test_red_to_green();
      int p = pulses[0];
      int seq [5] = '{10, 10, 11, 11, 11};
      for (int f = 0; f < 5; f++) begin
         if (seq[f] == 10) fill(N, 0); else fill(0, N);
         send_frame(N, -1);
         model_frame(N);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (c1[k] !== 8'(prev[k]) || v1[k] !== 1'b0 || c2[k] !== 8'(disp[k]) || v2[k] !== chg[k] || v3[k] !== 1'b0) begin
               failures++;
               $display("FAIL red_to_green dut%0d frame%0d: got char %0d->%0d valid %b%b%b, want %0d->%0d valid 0%b0",
                        k, f, c1[k], c2[k], v1[k], v2[k], v3[k], prev[k], disp[k], chg[k]);
            end
         end
         checks++;
         if (ch[0] !== ((f == 4) ? 8'd11 : 8'd10)) begin
            failures++;
            $display("FAIL red_to_green char frame%0d: got %0d, want %0d", f, ch[0], (f == 4) ? 11 : 10);
         end
      end
      checks++;
      if (pulses[0] - p !== 1) begin
         failures++;
         $display("FAIL red_to_green pulses: got %0d, want 1", pulses[0] - p);
      end
   endtask

   task automatic test_threshold();
      int nr [5] = '{0, 19, 20, 0, 64};
      int ng [5] = '{40, 0, 0, 40, 64};
      int want [5] = '{11, 15, 10, 11, 10};
      for (int f = 0; f < 5; f++) begin
         fill(nr[f], ng[f]);
         send_frame(N, -1);
         model_frame(N);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (c1[k] !== 8'(prev[k]) || v1[k] !== 1'b0 || c2[k] !== 8'(disp[k]) || v2[k] !== chg[k] || v3[k] !== 1'b0) begin
               failures++;
               $display("FAIL threshold dut%0d frame%0d: got char %0d->%0d valid %b%b%b, want %0d->%0d valid 0%b0",
                        k, f, c1[k], c2[k], v1[k], v2[k], v3[k], prev[k], disp[k], chg[k]);
            end
         end
         checks++;
         if (ch[2] !== 8'(want[f])) begin
            failures++;
            $display("FAIL threshold class red=%0d green=%0d: got %0d, want %0d", nr[f], ng[f], ch[2], want[f]);
         end
      end
   endtask

   task automatic test_roi();
      rst = 1; tick(); rst = 0;
      model_reset();
      for (int f = 0; f < 3; f++) begin
         fill(0, 0);
         for (int y = 0; y < V; y++) pix[y * H] = red_px();
         for (int n = 0; n < 12; n++) pix[(n % V) * H + 1 + n / V] = red_px();
         send_frame(N, -1);
         model_frame(N);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (c1[k] !== 8'(prev[k]) || v1[k] !== 1'b0 || c2[k] !== 8'(disp[k]) || v2[k] !== chg[k] || v3[k] !== 1'b0) begin
               failures++;
               $display("FAIL roi dut%0d frame%0d: got char %0d->%0d valid %b%b%b, want %0d->%0d valid 0%b0",
                        k, f, c1[k], c2[k], v1[k], v2[k], v3[k], prev[k], disp[k], chg[k]);
            end
         end
      end
      checks++;
      if (ch[0] !== 8'd10 || ch[1] !== 8'd15) begin
         failures++;
         $display("FAIL roi column0: got full=%0d x0_1=%0d, want 10 15", ch[0], ch[1]);
      end
   endtask

   task automatic test_partial_empty();
      int npx [3] = '{N, 55, 0};
      int want [3] = '{11, 10, 15};
      for (int f = 0; f < 3; f++) begin
         if (f == 0) fill(0, N); else fill(N, 0);
         send_frame(npx[f], -1);
         model_frame(npx[f]);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (c1[k] !== 8'(prev[k]) || v1[k] !== 1'b0 || c2[k] !== 8'(disp[k]) || v2[k] !== chg[k] || v3[k] !== 1'b0) begin
               failures++;
               $display("FAIL partial_empty dut%0d frame%0d: got char %0d->%0d valid %b%b%b, want %0d->%0d valid 0%b0",
                        k, f, c1[k], c2[k], v1[k], v2[k], v3[k], prev[k], disp[k], chg[k]);
            end
         end
         checks++;
         if (ch[2] !== 8'(want[f])) begin
            failures++;
            $display("FAIL partial_empty pixels=%0d: got %0d, want %0d", npx[f], ch[2], want[f]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int kind [9] = '{1, 1, 1, 0, 0, 2, 0, 0, 0};
      for (int f = 0; f < 9; f++) begin
         if (kind[f] == 1) fill(0, N); else fill(N, 0);
         send_frame(N, (kind[f] == 2) ? 4 * H + 8 : -1);
         if (kind[f] == 2) begin
            model_reset();
            for (int k = 0; k < 3; k++) begin
               checks++;
               if (rc[k] !== 8'd15 || rv[k] !== 1'b0) begin
                  failures++;
                  $display("FAIL mid_reset dut%0d: got char %0d valid %b after rst, want 15 0", k, rc[k], rv[k]);
               end
            end
         end else model_frame(N);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (c1[k] !== 8'(prev[k]) || v1[k] !== 1'b0 || c2[k] !== 8'(disp[k]) || v2[k] !== chg[k] || v3[k] !== 1'b0) begin
               failures++;
               $display("FAIL mid_reset dut%0d frame%0d: got char %0d->%0d valid %b%b%b, want %0d->%0d valid 0%b0",
                        k, f, c1[k], c2[k], v1[k], v2[k], v3[k], prev[k], disp[k], chg[k]);
            end
         end
         if (f >= 7) begin
            checks++;
            if (ch[0] !== ((f == 8) ? 8'd10 : 8'd15)) begin
               failures++;
               $display("FAIL mid_reset recovery frame%0d: got %0d, want %0d", f, ch[0], (f == 8) ? 10 : 15);
            end
         end
      end
   endtask

   task automatic test_stable_one();
      int p;
      for (int f = 0; f < 6; f++) begin
         p = pulses[2];
         if (f % 2 == 0) fill(0, N); else fill(N, 0);
         send_frame(N, -1);
         model_frame(N);
         checks++;
         if (ch[2] !== ((f % 2 == 0) ? 8'd11 : 8'd10) || pulses[2] - p !== 1 || c2[2] !== 8'(disp[2])) begin
            failures++;
            $display("FAIL stable_one frame%0d: got char %0d pulses %0d, want %0d pulses 1",
                     f, ch[2], pulses[2] - p, (f % 2 == 0) ? 11 : 10);
         end
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) pulses[k] = 0;
      model_reset();
      test_reset();
      test_passthrough();
      test_red_debounce();
      test_red_to_green();
      test_threshold();
      test_roi();
      test_partial_empty();
      test_mid_reset();
      test_stable_one();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
